// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: arbiter state encoding, ethertypes, source indices.
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        STREAM,
        GAP
    } tx_arb_state_t;

    localparam logic [15:0] ETH_ARP  = 16'h0806;
    localparam logic [15:0] ETH_IPV4 = 16'h0800;

    localparam int SRC_ARP  = 0;
    localparam int SRC_IPV4 = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/eth_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap-around.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    int cand;

    // Scan N candidates starting at ptr; the first requester found wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!valid && req[cand]) begin
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Shares one MAC TX frame encoder between N_SRC payload sources: round-robin grant,
// header latching, byte-pull steering, start timeout and inter-frame gap.
module eth_tx_arbiter
    import eth_pkg::*;
#(
    parameter int N_SRC         = 2,
    parameter int IFG_CYCLES    = 12,
    parameter int START_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SRC-1:0]     req,
    input  logic [48*N_SRC-1:0]  req_dest,
    input  logic [16*N_SRC-1:0]  req_ethertype,
    input  logic [N_SRC-1:0]     src_valid,
    input  logic [8*N_SRC-1:0]   src_data,
    output logic [N_SRC-1:0]     src_en,
    output logic [N_SRC-1:0]     grant,
    output logic                 enc_en,
    output logic [47:0]          enc_dest,
    output logic [15:0]          enc_ethertype,
    output logic [7:0]           enc_payload,
    input  logic                 enc_send_next,
    output logic                 busy,
    output logic                 abort
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CNT_W = $clog2(max_int(IFG_CYCLES, START_TIMEOUT) + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(START_TIMEOUT - 1);

    tx_arb_state_t    state_q, state_d;
    logic [N_SRC-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] gidx_q, gidx_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [47:0]      dest_q, dest_d;
    logic [15:0]      etype_q, etype_d;
    logic             abort_q, abort_d;

    logic [N_SRC-1:0] arb_grant;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_valid;

    logic             g_valid;
    logic [7:0]       g_data;
    logic             hs;

    rr_arbiter #(
        .N     (N_SRC),
        .IDX_W (IDX_W)
    ) u_rr (
        .req   (req),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // Steer the encoder's byte pull to the granted source while the frame is open.
    always_comb begin
        g_valid     = src_valid[gidx_q];
        g_data      = src_data[8*gidx_q +: 8];
        hs          = enc_send_next && g_valid && ((state_q == START) || (state_q == STREAM));
        enc_payload = hs ? g_data : 8'h00;
        src_en      = hs ? grant_q : '0;
    end

    assign grant         = grant_q;
    assign enc_en        = (state_q == START) || (state_q == STREAM);
    assign enc_dest      = dest_q;
    assign enc_ethertype = etype_q;
    assign busy          = (state_q != IDLE);
    assign abort         = abort_q;

    // Next-state logic: arbitration, start timeout, end-of-frame detection, gap timing.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        dest_d   = dest_q;
        etype_d  = etype_q;
        abort_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d  = arb_grant;
                    gidx_d   = arb_idx;
                    dest_d   = req_dest[48*arb_idx +: 48];
                    etype_d  = req_ethertype[16*arb_idx +: 16];
                    rr_ptr_d = (arb_idx == IDX_W'(N_SRC - 1)) ? '0 : arb_idx + 1'b1;
                    cnt_d    = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (enc_send_next) begin
                    state_d = STREAM;
                end else if (cnt_q >= TO_LAST) begin
                    abort_d = 1'b1;
                    grant_d = '0;
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                end
            end
            STREAM: begin
                // The encoder asking for a byte the source no longer has marks end of payload.
                if (enc_send_next && !g_valid) begin
                    grant_d = '0;
                    cnt_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cnt_q >= IFG_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            dest_q   <= '0;
            etype_q  <= '0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            dest_q   <= dest_d;
            etype_q  <= etype_d;
            abort_q  <= abort_d;
        end
    end

endmodule
